// File: rtl/vid_pkg.sv
// +----------------------------------------------------------------------+
// | vid_pkg: shared types and default timing for the ZX raster generator |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
`default_nettype none

package vid_pkg;

    localparam int CNT_W = 10;

    localparam int DEF_H_TOTAL      = 448;
    localparam int DEF_H_ACTIVE     = 256;
    localparam int DEF_H_SYNC_START = 320;
    localparam int DEF_H_SYNC_LEN   = 32;
    localparam int DEF_V_TOTAL      = 320;
    localparam int DEF_V_ACTIVE     = 192;
    localparam int DEF_V_SYNC_START = 240;
    localparam int DEF_V_SYNC_LEN   = 16;

    typedef struct packed {
        logic [1:0] r;
        logic [1:0] g;
        logic [1:0] b;
    } rgb222_t;

    typedef enum logic [1:0] {
        SOLID   = 2'd0,
        BARS    = 2'd1,
        CHECKER = 2'd2,
        SCROLL  = 2'd3
    } vid_mode_e;

    // ZX GRB attribute bits to full-intensity 2:2:2 colour.
    function automatic rgb222_t zx_expand(input logic [2:0] grb);
        rgb222_t c;
        c.r = {2{grb[1]}};
        c.g = {2{grb[2]}};
        c.b = {2{grb[0]}};
        return c;
    endfunction

endpackage

`default_nettype wire

// File: rtl/vid_axis_cnt.sv
// +----------------------------------------------------------------------+
// | vid_axis_cnt: wrapping raster axis counter with active/sync decode   |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
`default_nettype none

module vid_axis_cnt
    import vid_pkg::*;
#(
    parameter int TOTAL      = DEF_H_TOTAL,
    parameter int ACTIVE     = DEF_H_ACTIVE,
    parameter int SYNC_START = DEF_H_SYNC_START,
    parameter int SYNC_LEN   = DEF_H_SYNC_LEN
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             adv,
    output logic [CNT_W-1:0] cnt,
    output logic             wrap,
    output logic             active,
    output logic             sync
);

    // Decodes are done one bit wider so parameters equal to 1024 still compare correctly.
    localparam logic [CNT_W-1:0] C_LAST       = CNT_W'(TOTAL - 1);
    localparam logic [CNT_W:0]   C_ACTIVE     = (CNT_W+1)'(ACTIVE);
    localparam logic [CNT_W:0]   C_SYNC_START = (CNT_W+1)'(SYNC_START);
    localparam logic [CNT_W+1:0] C_SYNC_END   = (CNT_W+2)'(SYNC_START + SYNC_LEN);

    logic [CNT_W-1:0] r_cnt;
    logic             w_at_last;

    assign w_at_last = (r_cnt == C_LAST);
    assign wrap      = adv && w_at_last;
    assign cnt       = r_cnt;
    assign active    = ({1'b0, r_cnt} < C_ACTIVE);
    assign sync      = ({1'b0, r_cnt} >= C_SYNC_START) && ({2'b00, r_cnt} < C_SYNC_END);

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_cnt <= '0;
        end else if (adv) begin
            r_cnt <= w_at_last ? '0 : r_cnt + 1'b1;
        end
    end

endmodule

`default_nettype wire

// File: rtl/zx_vidgen.sv
// +----------------------------------------------------------------------+
// | zx_vidgen: ZX-style 2:2:2 raster and test-pattern generator          |
// | Option macro VIDGEN_BORDER_EN adds a frame-latched border colour.    |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
`default_nettype none

module zx_vidgen
    import vid_pkg::*;
#(
    parameter int H_TOTAL      = DEF_H_TOTAL,
    parameter int H_ACTIVE     = DEF_H_ACTIVE,
    parameter int H_SYNC_START = DEF_H_SYNC_START,
    parameter int H_SYNC_LEN   = DEF_H_SYNC_LEN,
    parameter int V_TOTAL      = DEF_V_TOTAL,
    parameter int V_ACTIVE     = DEF_V_ACTIVE,
    parameter int V_SYNC_START = DEF_V_SYNC_START,
    parameter int V_SYNC_LEN   = DEF_V_SYNC_LEN
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [1:0] mode,
    input  logic [5:0] color,
`ifdef VIDGEN_BORDER_EN
    input  logic [2:0] border,
`endif
    output logic       hsync,
    output logic       vsync,
    output logic [1:0] red,
    output logic [1:0] grn,
    output logic [1:0] blu,
    output logic       frame_start
);

    logic [CNT_W-1:0] w_h_cnt;
    logic [CNT_W-1:0] w_v_cnt;
    logic             w_h_wrap;
    logic             w_v_wrap;
    logic             w_h_act;
    logic             w_v_act;
    logic             w_h_sync;
    logic             w_v_sync;

    vid_axis_cnt #(
        .TOTAL      (H_TOTAL),
        .ACTIVE     (H_ACTIVE),
        .SYNC_START (H_SYNC_START),
        .SYNC_LEN   (H_SYNC_LEN)
    ) u_h_cnt (
        .clk    (clk),
        .rst_n  (rst_n),
        .adv    (1'b1),
        .cnt    (w_h_cnt),
        .wrap   (w_h_wrap),
        .active (w_h_act),
        .sync   (w_h_sync)
    );

    vid_axis_cnt #(
        .TOTAL      (V_TOTAL),
        .ACTIVE     (V_ACTIVE),
        .SYNC_START (V_SYNC_START),
        .SYNC_LEN   (V_SYNC_LEN)
    ) u_v_cnt (
        .clk    (clk),
        .rst_n  (rst_n),
        .adv    (w_h_wrap),
        .cnt    (w_v_cnt),
        .wrap   (w_v_wrap),
        .active (w_v_act),
        .sync   (w_v_sync)
    );

    vid_mode_e r_mode;
    rgb222_t   r_color;
    logic [7:0] r_fcnt;
    rgb222_t   r_pix;
    logic      r_hsync;
    logic      r_vsync;
    logic      r_frame_start;

    logic      w_first;
    logic      w_active;
    vid_mode_e w_mode;
    rgb222_t   w_color;
    logic [7:0] w_x;
    logic      w_y3;
    logic [5:0] w_scroll;
    rgb222_t   w_pix;

    assign w_first  = (w_h_cnt == '0) && (w_v_cnt == '0);
    assign w_active = w_h_act && w_v_act;

    // At (0,0) the pattern uses the live inputs so the capture applies to this very pixel.
    assign w_mode   = w_first ? vid_mode_e'(mode) : r_mode;
    assign w_color  = w_first ? rgb222_t'(color) : r_color;

    assign w_x      = w_h_cnt[7:0];
    assign w_y3     = w_v_cnt[3];
    assign w_scroll = 6'((w_x + r_fcnt) >> 2);

`ifdef VIDGEN_BORDER_EN
    logic [2:0] r_border;
    logic [2:0] w_border;

    assign w_border = w_first ? border : r_border;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_border <= '0;
        end else if (w_first) begin
            r_border <= border;
        end
    end
`endif

    always_comb begin
        w_pix = '0;
        if (w_active) begin
            case (w_mode)
                SOLID:   w_pix = w_color;
                BARS:    w_pix = zx_expand(w_x[7:5]);
                CHECKER: w_pix = (w_x[3] ^ w_y3) ? w_color : '0;
                SCROLL:  w_pix = rgb222_t'(w_scroll);
                default: w_pix = '0;
            endcase
        end
`ifdef VIDGEN_BORDER_EN
        else if (!w_h_sync && !w_v_sync) begin
            w_pix = zx_expand(w_border);
        end
`endif
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_mode  <= SOLID;
            r_color <= '0;
            r_fcnt  <= '0;
        end else begin
            if (w_first) begin
                r_mode  <= vid_mode_e'(mode);
                r_color <= rgb222_t'(color);
            end
            if (w_h_wrap && w_v_wrap) begin
                r_fcnt <= r_fcnt + 8'd1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_pix         <= '0;
            r_hsync       <= 1'b0;
            r_vsync       <= 1'b0;
            r_frame_start <= 1'b0;
        end else begin
            r_pix         <= w_pix;
            r_hsync       <= w_h_sync;
            r_vsync       <= w_v_sync;
            r_frame_start <= w_first;
        end
    end

    assign hsync       = r_hsync;
    assign vsync       = r_vsync;
    assign red         = r_pix.r;
    assign grn         = r_pix.g;
    assign blu         = r_pix.b;
    assign frame_start = r_frame_start;

endmodule

`default_nettype wire

// File: tb/tb_zx_vidgen.sv
// +----------------------------------------------------------------------+
// | tb_zx_vidgen: two reduced-timing zx_vidgen instances vs a raster model|
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
`default_nettype none

module tb_zx_vidgen;

    localparam int BHT = 300, BHA = 256, BHS = 272, BHL = 16;
    localparam int BVT = 20,  BVA = 12,  BVS = 14,  BVL = 3;
    localparam int SHT = 16,  SHA = 8,   SHS = 10,  SHL = 3;
    localparam int SVT = 4,   SVA = 2,   SVS = 3,   SVL = 1;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic [1:0] mode = 2'd0;
    logic [5:0] color = 6'd0;
    logic [2:0] border = 3'd0;

    logic       b_hsync, b_vsync, b_fs, s_hsync, s_vsync, s_fs;
    logic [1:0] b_red, b_grn, b_blu, s_red, s_grn, s_blu;
    logic [8:0] b_obs, s_obs;
    logic [5:0] b_rgb, s_rgb;

    assign b_obs = {b_hsync, b_vsync, b_fs, b_red, b_grn, b_blu};
    assign s_obs = {s_hsync, s_vsync, s_fs, s_red, s_grn, s_blu};
    assign b_rgb = {b_red, b_grn, b_blu};
    assign s_rgb = {s_red, s_grn, s_blu};

    always #5 clk = ~clk;

    zx_vidgen #(
        .H_TOTAL(BHT), .H_ACTIVE(BHA), .H_SYNC_START(BHS), .H_SYNC_LEN(BHL),
        .V_TOTAL(BVT), .V_ACTIVE(BVA), .V_SYNC_START(BVS), .V_SYNC_LEN(BVL)
    ) dut_big (
        .clk(clk), .rst_n(rst_n), .mode(mode), .color(color),
`ifdef VIDGEN_BORDER_EN
        .border(border),
`endif
        .hsync(b_hsync), .vsync(b_vsync), .red(b_red), .grn(b_grn), .blu(b_blu),
        .frame_start(b_fs)
    );

    zx_vidgen #(
        .H_TOTAL(SHT), .H_ACTIVE(SHA), .H_SYNC_START(SHS), .H_SYNC_LEN(SHL),
        .V_TOTAL(SVT), .V_ACTIVE(SVA), .V_SYNC_START(SVS), .V_SYNC_LEN(SVL)
    ) dut_small (
        .clk(clk), .rst_n(rst_n), .mode(mode), .color(color),
`ifdef VIDGEN_BORDER_EN
        .border(border),
`endif
        .hsync(s_hsync), .vsync(s_vsync), .red(s_red), .grn(s_grn), .blu(s_blu),
        .frame_start(s_fs)
    );

    int         checks = 0;
    int         errors = 0;
    longint     t_m[2];
    logic [1:0] sh_mode[2];
    logic [5:0] sh_col[2];
    logic [2:0] sh_brd[2];
    logic [8:0] exp_v[2];
    bit         model_ok = 1'b0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        checks++;
        assert (obs === expv) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
        end
    endtask

    // Expected {hsync,vsync,frame_start,rgb} for the t-th pixel clock after reset release.
    function automatic logic [8:0] calc(input int i, input longint t, input logic [1:0] md,
                                        input logic [5:0] col, input logic [2:0] brd);
        int ht, ha, hs0, hl, vt, va, vs0, vl, h, v, fr, b, s;
        bit act, hs, vs, fs;
        logic [5:0] rgb;
        if (i == 0) begin
            ht = BHT; ha = BHA; hs0 = BHS; hl = BHL; vt = BVT; va = BVA; vs0 = BVS; vl = BVL;
        end else begin
            ht = SHT; ha = SHA; hs0 = SHS; hl = SHL; vt = SVT; va = SVA; vs0 = SVS; vl = SVL;
        end
        h   = int'(t % longint'(ht));
        v   = int'((t / longint'(ht)) % longint'(vt));
        fr  = int'((t / longint'(ht * vt)) % 256);
        act = (h < ha) && (v < va);
        hs  = (h >= hs0) && (h < hs0 + hl);
        vs  = (v >= vs0) && (v < vs0 + vl);
        fs  = (h == 0) && (v == 0);
        rgb = 6'd0;
        if (act) begin
            case (md)
                2'd0: rgb = col;
                2'd1: begin
                    b   = (h % 256) / 32;
                    rgb = {2'(((b / 2) % 2) * 3), 2'(((b / 4) % 2) * 3), 2'((b % 2) * 3)};
                end
                2'd2: rgb = ((((h % 256) / 8) % 2) != (((v % 256) / 8) % 2)) ? col : 6'd0;
                default: begin
                    s   = (h + fr) % 256;
                    rgb = 6'(s / 4);
                end
            endcase
        end else if (!hs && !vs) begin
`ifdef VIDGEN_BORDER_EN
            rgb = {{2{brd[1]}}, {2{brd[2]}}, {2{brd[0]}}};
`else
            rgb = (brd == 3'd7) ? 6'd0 : 6'd0;
`endif
        end
        return {hs, vs, fs, rgb};
    endfunction

    task automatic tick();
        longint fp;
        @(posedge clk);
        for (int i = 0; i < 2; i++) begin
            fp = (i == 0) ? longint'(BHT * BVT) : longint'(SHT * SVT);
            if (!rst_n) begin
                t_m[i] = 0; sh_mode[i] = 2'd0; sh_col[i] = 6'd0; sh_brd[i] = 3'd0;
                exp_v[i] = 9'd0;
            end else begin
                if (t_m[i] % fp == 0) begin
                    sh_mode[i] = mode; sh_col[i] = color; sh_brd[i] = border;
                end
                exp_v[i] = calc(i, t_m[i], sh_mode[i], sh_col[i], sh_brd[i]);
                t_m[i]++;
            end
        end
        if (!rst_n) model_ok = 1'b1;
        #1;
        if (model_ok) begin
            check("big_px", 32'(b_obs), 32'(exp_v[0]));
            check("small_px", 32'(s_obs), 32'(exp_v[1]));
        end
    endtask

    initial begin
        int fs_cnt, rises, hs_hi, vs_hi, last_rise, x, y;
        bit prev_hs, found;
        logic [5:0] v0;

        // Reset
        rst_n = 1'b0;
        repeat (3) tick();
        check("rst_state_big", 32'(b_obs), 32'd0);
        check("rst_state_small", 32'(s_obs), 32'd0);

        // Defaults: sync periods and frame_start cadence over two big frames
        rst_n = 1'b1; mode = 2'd0; color = 6'd0; border = 3'($urandom_range(0, 7));
        fs_cnt = 0; rises = 0; hs_hi = 0; vs_hi = 0; last_rise = -1; prev_hs = 1'b0;
        for (int k = 0; k < 2 * BHT * BVT; k++) begin
            tick();
            if (k == 0) check("fs_first", 32'(b_fs), 32'd1);
            if (s_fs) fs_cnt++;
            if (b_hsync) hs_hi++;
            if (b_vsync) vs_hi++;
            if (b_hsync && !prev_hs) begin
                if (last_rise >= 0) check("hsync_gap", 32'(k - last_rise), 32'(BHT));
                last_rise = k;
                rises++;
            end
            prev_hs = b_hsync;
        end
        check("fs_count_small", 32'(fs_cnt), 32'd188);
        check("hsync_rises", 32'(rises), 32'd40);
        check("hsync_high", 32'(hs_hi), 32'd640);
        check("vsync_high", 32'(vs_hi), 32'(2 * BVL * BHT));

        // Bars on line 0
        mode = 2'd1;
        for (int k = 0; k < BHT * BVT; k++) begin
            tick();
            if (k >= 32 && k < 64) check("bars_blue", 32'(b_rgb), 32'h03);
            if (k >= 224 && k < 256) check("bars_white", 32'(b_rgb), 32'h3F);
            if (k >= 256 && k < BHT) check("bars_blank", 32'(b_rgb), 32'h00);
        end

        // Checker
        mode = 2'd2; color = 6'h3F;
        for (int k = 0; k < BHT * BVT; k++) begin
            tick();
            if (k == 0) check("chk_0_0", 32'(b_rgb), 32'h00);
            if (k == 8) check("chk_8_0", 32'(b_rgb), 32'h3F);
            if (k == 8 * BHT + 8) check("chk_8_8", 32'(b_rgb), 32'h00);
        end

        // Mid-frame colour change must not tear
        mode = 2'd0; color = 6'h30;
        for (int k = 0; k < BHT * BVT + BHT; k++) begin
            if (k == 6 * BHT) color = 6'h0C;
            tick();
            x = k % BHT;
            y = (k / BHT) % BVT;
            if (x < BHA && y < BVA) begin
                if (k < BHT * BVT) check("tear_frame_n", 32'(b_rgb), 32'h30);
                else check("tear_frame_n1", 32'(b_rgb), 32'h0C);
            end
        end

        // Random mode/colour churn, checked against the model every clock
        for (int k = 0; k < BHT * BVT; k++) begin
            if ($urandom_range(0, 19) == 0) begin
                mode   = 2'($urandom_range(0, 3));
                color  = 6'($urandom);
                border = 3'($urandom_range(0, 7));
            end
            tick();
        end

        // Reset for one clock at line 15
        found = 1'b0;
        for (int k = 0; k < BHT * BVT && !found; k++) begin
            if (t_m[0] % longint'(BHT * BVT) == longint'(15 * BHT)) found = 1'b1;
            else tick();
        end
        check("wait_line15", 32'(found), 32'd1);
        rst_n = 1'b0;
        tick();
        check("rst_mid_big", 32'(b_obs), 32'd0);
        check("rst_mid_small", 32'(s_obs), 32'd0);

        // Scroll: pixel x=0 follows fcnt and repeats after 256 frames
        rst_n = 1'b1; mode = 2'd3; v0 = 6'd0;
        for (int f = 0; f <= 256; f++) begin
            tick();
            if (f == 0) begin
                check("fs_after_rst_big", 32'(b_fs), 32'd1);
                check("fs_after_rst_small", 32'(s_fs), 32'd1);
                v0 = s_rgb;
            end
            check("scroll_x0", 32'(s_rgb), 32'((f % 256) / 4));
            if (f == 256) check("scroll_wrap", 32'(s_rgb), 32'(v0));
            repeat (SHT * SVT - 1) tick();
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/zx_vidgen.md
# zx_vidgen

Synthesizable ZX-style raster generator producing the 2:2:2 RGB and active-high sync stream that the simulation pixel visualizer consumes. Generates horizontal/vertical timing for a Pentagon-like 448×320 frame, a 256×192 active window, and one of four test patterns latched per frame. Sits directly upstream of the visualizer in `sim_top`, and doubles as a bring-up pattern source on hardware.

## Interface
- `H_TOTAL`, 448: clocks per line.
- `H_ACTIVE`, 256: active pixels per line, starting at hcnt 0.
- `H_SYNC_START`, 320: first hcnt with hsync high.
- `H_SYNC_LEN`, 32: hsync width, clocks.
- `V_TOTAL`, 320: lines per frame.
- `V_ACTIVE`, 192: active lines, starting at vcnt 0.
- `V_SYNC_START`, 240: first line with vsync high.
- `V_SYNC_LEN`, 16: vsync width, lines.
- `clk` in 1: pixel clock; the only clock.
- `rst_n` in 1: synchronous, active-low reset.
- `mode` in 2: pattern select, sampled at frame start.
- `color` in 6: {r1,r0,g1,g0,b1,b0} foreground, sampled at frame start.
- `hsync` out 1: active high.
- `vsync` out 1: active high, whole lines.
- `red`, `grn`, `blu` out 2 each: pixel colour; 0 when blanked.
- `frame_start` out 1: one-cycle pulse marking the output cycle of pixel (0,0).

## Operation
- hcnt runs 0..H_TOTAL-1 and wraps to 0. vcnt advances only on the hcnt wrap, runs 0..V_TOTAL-1 and wraps to 0. Both counters are 10 bits; all parameters must be ≤1024.
- Active region: hcnt<H_ACTIVE and vcnt<V_ACTIVE. Here x=hcnt[7:0] and y=vcnt[7:0].
- hsync=1 when H_SYNC_START ≤ hcnt < H_SYNC_START+H_SYNC_LEN. vsync=1 when V_SYNC_START ≤ vcnt < V_SYNC_START+V_SYNC_LEN.
- At counter state (0,0), `mode` and `color` are copied into shadow registers. They are not updated at any other time, so mid-frame changes never tear.
- fcnt (8-bit frame counter) increments on the wrap at (H_TOTAL-1, V_TOTAL-1), wrapping 255→0.
- Patterns, computed from the shadow registers:
  - mode 0, solid: rgb = color.
  - mode 1, bars: b = x[7:5]; red = {b[1],b[1]}, grn = {b[2],b[2]}, blu = {b[0],b[0]}. This gives 8 ZX bars, 32 px each.
  - mode 2, checker: rgb = (x[3]^y[3]) ? color : 0.
  - mode 3, scroll: s = (x+fcnt) mod 256; {red,grn,blu} = s[7:2].
- Outside the active region, rgb = 0.
- Reset state of all outputs: hsync=0, vsync=0, rgb=0, frame_start=0.
- Reset state of internal registers: hcnt=0, vcnt=0, fcnt=0, shadow mode=0, shadow color=0.

## Timing
- All outputs are registered, with a latency of 1 clock from counter state to output.
- The counter state (0,0) occurs on the first clock edge with rst_n=1. The outputs for that state, including frame_start=1, appear on the following cycle.
- Shadow capture at (0,0) takes effect for that same pixel: the pattern logic uses the freshly sampled mode/color value.
- Line period is H_TOTAL clocks. Frame period is H_TOTAL×V_TOTAL = 143360 clocks at the defaults.
- Reset mid-frame:
  - On the clock edge that samples rst_n=0, the counters return to 0 and the outputs go to their reset values.
  - No partial sync pulse is stretched.
  - After rst_n rises, the next frame starts cleanly.
- A simultaneous hcnt and vcnt wrap (frame end) also increments fcnt on the same edge.

## Configuration
- `VIDGEN_BORDER_EN` defined:
  - Adds input `border` (3 bits, ZX GRB). The border is sampled together with the other shadow registers at frame start.
  - In the non-active, non-sync region, output red={border[1],border[1]}, grn={border[2],border[2]}, blu={border[0],border[0]}.
  - During hsync or vsync, rgb stays 0.
- `VIDGEN_BORDER_EN` undefined: the port is absent and the whole non-active region is 0.

## Structure
- Shared package `vid_pkg` holds:
  - the `rgb222_t` packed struct;
  - the `vid_mode_e` enum (SOLID, BARS, CHECKER, SCROLL);
  - the default timing constants.
- One sub-module, `vid_axis_cnt`, is instantiated twice (horizontal and vertical). It contains:
  - the wrapping counter with an advance enable;
  - a wrap output;
  - active and sync decode outputs.

## Test plan
- Reset, then release with defaults:
  - frame_start pulses every 143360 clocks;
  - hsync rising edges are 448 clocks apart, each 32 clocks high;
  - vsync is high for 7168 clocks per frame.
- mode=1: on line 0, x=32..63 gives red=0, grn=0, blu=3; x=224..255 gives all components 3; x=256..447 gives all 0.
- mode=2, color=6'h3F: pixel (0,0) is 0; pixel (8,0) is 3F; pixel (8,8) is 0.
- mode=0/color=6'h30 in frame N, switched to mode=0/color=6'h0C at mid-frame line 100: the rest of frame N stays red=3; frame N+1 shows grn=3.
- mode=3: pixel x=0 shows s=fcnt; over 256 frames the pattern returns to its frame-0 value, confirming fcnt wrap 255→0.
- rst_n=0 for 1 cycle at line 150: the next cycle has all outputs 0; frame_start appears 2 cycles after rst_n returns high.
